// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, PC step,
// BTB geometry helpers and the EX branch-resolution bundle.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
    function automatic int btb_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    function automatic int btb_tag_w(input int entries);
        return 30 - $clog2(entries);
    endfunction

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
    } br_update_t;

endpackage

// File: rtl/if_stage_branch_target_buffer.sv
// Direct-mapped branch target buffer: combinational lookup, update at the clock edge.
// A lookup and an update to the same index in one cycle returns the old contents.
module branch_target_buffer
    import if_stage_pkg::*;
#(
    parameter int ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] lookup_pc_i,
    output logic        hit_o,
    output logic [31:0] target_o,
    input  br_update_t  upd_i
);

    localparam int IW = btb_idx_w(ENTRIES);
    localparam int TW = btb_tag_w(ENTRIES);

    logic [ENTRIES-1:0] valid_q;
    logic [TW-1:0]      tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];

    logic [IW-1:0] rd_idx;
    logic [TW-1:0] rd_tag;
    logic [IW-1:0] wr_idx;
    logic [TW-1:0] wr_tag;
    logic          wr_match;

    assign rd_idx = lookup_pc_i[2 +: IW];
    assign rd_tag = lookup_pc_i[31 -: TW];
    assign wr_idx = upd_i.pc[2 +: IW];
    assign wr_tag = upd_i.pc[31 -: TW];

    assign hit_o    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign target_o = {target_q[rd_idx], 2'b00};

    assign wr_match = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Only valid bits are cleared on reset; tag/target are qualified by valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (upd_i.valid) begin
            if (upd_i.taken) begin
                valid_q[wr_idx]  <= 1'b1;
                tag_q[wr_idx]    <= wr_tag;
                target_q[wr_idx] <= upd_i.target[31:2];
            end else if (wr_match) begin
                valid_q[wr_idx] <= 1'b0;
            end
        end
    end

    logic unused_low_bits;
    assign unused_low_bits = ^{lookup_pc_i[1:0], upd_i.pc[1:0], upd_i.target[1:0]};

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC, picks next PC (reset/redirect/stall/BTB/+4).
// Optional BTB selected by macro IF_BTB_EN; fetch_addr is 0-cycle, id_pc 1-cycle.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int          BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        ex_br_update,
    input  logic [31:0] ex_br_pc,
    input  logic [31:0] ex_br_target,
    input  logic        ex_br_taken,
    output logic [31:0] fetch_addr,
    output logic [31:0] id_pc,
    output logic        id_target_taken
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic        btb_hit;
    logic [31:0] btb_target;

`ifdef IF_BTB_EN
    br_update_t br_upd;

    assign br_upd = '{valid: ex_br_update, pc: ex_br_pc,
                      target: ex_br_target, taken: ex_br_taken};

    branch_target_buffer #(
        .ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk         (clk),
        .rst         (rst),
        .lookup_pc_i (pc_q),
        .hit_o       (btb_hit),
        .target_o    (btb_target),
        .upd_i       (br_upd)
    );
`else
    assign btb_hit    = 1'b0;
    assign btb_target = '0;

    logic unused_br;
    assign unused_br = ^{ex_br_update, ex_br_pc, ex_br_target, ex_br_taken};
`endif

    // Redirect beats stall: decode is flushed on redirect anyway.
    always_comb begin
        pc_d = pc_q + PC_INC;
        if (rst) begin
            pc_d = RESET_PC;
        end else if (ex_redirect) begin
            pc_d = ex_redirect_pc;
        end else if (id_stall) begin
            pc_d = pc_q;
        end else if (btb_hit) begin
            pc_d = btb_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fetch_addr      = pc_d;
    assign id_pc           = pc_q;
    assign id_target_taken = btb_hit && !rst;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table, then random traffic against a map-based model.
module tb_if_stage;

`ifdef IF_BTB_EN
    localparam bit BTB_EN = 1'b1;
`else
    localparam bit BTB_EN = 1'b0;
`endif
    localparam logic [31:0] RST_PC = 32'h4000_0000;
    localparam int          NENT   = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_redirect_pc;
    logic        ex_br_update;
    logic [31:0] ex_br_pc;
    logic [31:0] ex_br_target;
    logic        ex_br_taken;
    logic [31:0] fetch_addr;
    logic [31:0] id_pc;
    logic        id_target_taken;

    always #5 clk = ~clk;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_stall        (id_stall),
        .ex_redirect     (ex_redirect),
        .ex_redirect_pc  (ex_redirect_pc),
        .ex_br_update    (ex_br_update),
        .ex_br_pc        (ex_br_pc),
        .ex_br_target    (ex_br_target),
        .ex_br_taken     (ex_br_taken),
        .fetch_addr      (fetch_addr),
        .id_pc           (id_pc),
        .id_target_taken (id_target_taken)
    );

    typedef struct {
        bit          rst;
        bit          stall;
        bit          redir;
        logic [31:0] rpc;
        bit          upd;
        logic [31:0] upc;
        logic [31:0] utgt;
        bit          utk;
        logic [31:0] efetch;
        bit          ett;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit r, bit s, bit rd, logic [31:0] rpc, bit u,
                                logic [31:0] upc, logic [31:0] utgt, bit utk,
                                logic [31:0] ef, bit ett);
        vec_t v;
        v.rst = r; v.stall = s; v.redir = rd; v.rpc = rpc;
        v.upd = u; v.upc = upc; v.utgt = utgt; v.utk = utk;
        v.efetch = ef; v.ett = ett;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        rst            = v.rst;
        id_stall       = v.stall;
        ex_redirect    = v.redir;
        ex_redirect_pc = v.rpc;
        ex_br_update   = v.upd;
        ex_br_pc       = v.upc;
        ex_br_target   = v.utgt;
        ex_br_taken    = v.utk;
    endtask

    // Reference BTB: word address -> aligned target; at most one word address per index.
    logic [31:0] m_btb [logic [29:0]];
    logic [31:0] m_pc;

    task automatic model_update(input logic [31:0] pc, input logic [31:0] tgt, input bit taken);
        logic [29:0] key;
        logic [29:0] victims[$];
        key = pc[31:2];
        if (taken) begin
            foreach (m_btb[k]) if ((k % NENT) == (key % NENT)) victims.push_back(k);
            foreach (victims[i]) m_btb.delete(victims[i]);
            m_btb[key] = {tgt[31:2], 2'b00};
        end else if (m_btb.exists(key)) begin
            m_btb.delete(key);
        end
    endtask

    function automatic logic [31:0] pick_pc();
        logic [31:0] a;
        a = 32'h1000_0000 | (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 7)) << 2);
        return a;
    endfunction

    vec_t vecs[$];

    initial begin
        logic [31:0] E100, E200, E300;
        vec_t v;
        E100 = BTB_EN ? 32'h1000_0100 : 32'h1000_0014;
        E200 = BTB_EN ? 32'h1000_0200 : 32'h1000_0054;
        E300 = BTB_EN ? 32'h1000_0300 : 32'h1000_0014;

        vecs.push_back(mk(1,0,0,0,             0,0,0,0,                          32'h4000_0000,0));
        vecs.push_back(mk(1,0,0,0,             0,0,0,0,                          32'h4000_0000,0));
        vecs.push_back(mk(1,0,0,0,             0,0,0,0,                          32'h4000_0000,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h4000_0004,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h4000_0008,0));
        vecs.push_back(mk(0,1,0,0,             0,0,0,0,                          32'h4000_0008,0));
        vecs.push_back(mk(0,1,0,0,             0,0,0,0,                          32'h4000_0008,0));
        vecs.push_back(mk(0,1,1,32'h1000_0040, 0,0,0,0,                          32'h1000_0040,0));
        vecs.push_back(mk(0,0,0,0,             1,32'h1000_0010,32'h1000_0100,1,  32'h1000_0044,0));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 0,0,0,0,                          32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          E100,BTB_EN));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 1,32'h1000_0010,32'h0,0,          32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h1000_0014,0));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 1,32'h1000_0050,32'h1000_0200,1,  32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h1000_0014,0));
        vecs.push_back(mk(0,0,1,32'h1000_0050, 0,0,0,0,                          32'h1000_0050,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          E200,BTB_EN));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 0,0,0,0,                          32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             1,32'h1000_0010,32'h1000_0300,1,  32'h1000_0014,0));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 0,0,0,0,                          32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          E300,BTB_EN));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 0,0,0,0,                          32'h1000_0010,0));
        vecs.push_back(mk(0,1,0,0,             0,0,0,0,                          32'h1000_0010,BTB_EN));
        vecs.push_back(mk(0,0,1,32'h2000_0000, 0,0,0,0,                          32'h2000_0000,BTB_EN));
        vecs.push_back(mk(0,0,1,32'hFFFF_FFFC, 0,0,0,0,                          32'hFFFF_FFFC,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h0000_0000,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h0000_0004,0));
        vecs.push_back(mk(1,0,0,0,             1,32'h0000_0004,32'h5000_0000,1,  32'h4000_0000,0));
        vecs.push_back(mk(0,0,1,32'h0000_0004, 0,0,0,0,                          32'h0000_0004,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h0000_0008,0));
        vecs.push_back(mk(0,0,1,32'h1000_0010, 0,0,0,0,                          32'h1000_0010,0));
        vecs.push_back(mk(0,0,0,0,             0,0,0,0,                          32'h1000_0014,0));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            @(negedge clk);
            check32($sformatf("row%0d fetch_addr", i), fetch_addr, vecs[i].efetch);
            check1 ($sformatf("row%0d id_target_taken", i), id_target_taken, vecs[i].ett);
            @(posedge clk);
            #1;
            check32($sformatf("row%0d id_pc", i), id_pc, vecs[i].efetch);
        end

        m_btb.delete();
        m_pc = RST_PC;
        for (int n = 0; n < 2000; n++) begin
            logic        hit;
            logic [31:0] tgt;
            logic [31:0] exp;
            bit          ett;
            v.rst   = (n == 0) || ($urandom_range(0, 99) < 2);
            v.stall = ($urandom_range(0, 99) < 25);
            v.redir = ($urandom_range(0, 99) < 20);
            v.rpc   = pick_pc();
            if ($urandom_range(0, 9) == 0) v.rpc[1:0] = 2'($urandom_range(0, 3));
            v.upd   = ($urandom_range(0, 99) < 40);
            v.upc   = pick_pc();
            v.upc[1:0] = 2'($urandom_range(0, 3));
            v.utgt  = pick_pc();
            v.utgt[1:0] = 2'($urandom_range(0, 3));
            v.utk   = ($urandom_range(0, 99) < 60);
            v.efetch = '0;
            v.ett    = 1'b0;
            drive(v);
            @(negedge clk);
            hit = BTB_EN && m_btb.exists(m_pc[31:2]);
            tgt = hit ? m_btb[m_pc[31:2]] : 32'h0;
            ett = hit && !v.rst;
            if (v.rst)        exp = RST_PC;
            else if (v.redir) exp = v.rpc;
            else if (v.stall) exp = m_pc;
            else if (hit)     exp = tgt;
            else              exp = m_pc + 32'd4;
            check32($sformatf("rand%0d fetch_addr", n), fetch_addr, exp);
            check1 ($sformatf("rand%0d id_target_taken", n), id_target_taken, ett);
            if (v.rst) m_btb.delete();
            else if (BTB_EN && v.upd) model_update(v.upc, v.utgt, v.utk);
            m_pc = exp;
            @(posedge clk);
            #1;
            check32($sformatf("rand%0d id_pc", n), id_pc, m_pc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
